// File: rtl/bcd_bin_codec.sv
// Multi-cycle packed-BCD <-> unsigned binary converter with a start/busy/done handshake.
// Mode 0 does a digit-serial multiply-accumulate; mode 1 runs double dabble.
module bcd_bin_codec #(
    parameter int DIGITS = 3,
    parameter int BW     = 10,
    parameter int CW     = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  mode,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic [BW-1:0]         bin_in,
    output logic [BW-1:0]         bin_out,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int DW = 4 * DIGITS;
    localparam logic [CW-1:0] LAST_B2 = CW'(DIGITS - 1);
    localparam logic [CW-1:0] LAST_D2 = CW'(BW - 1);
    localparam longint unsigned MAX_BIN = 64'(10 ** DIGITS) - 64'd1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic              mode_q, mode_d;
    logic              inval_q, inval_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DW-1:0]     src_q, src_d;
    logic [BW-1:0]     acc_q, acc_d;
    logic [DW-1:0]     dd_q, dd_d;
    logic [BW-1:0]     bin_out_q, bin_out_d;
    logic [DW-1:0]     bcd_out_q, bcd_out_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [DIGITS-1:0] digit_bad;
    logic              bad_digit;
    logic              ovf;
    logic [DW-1:0]     dd_adj;
    logic [DW+BW-1:0]  dd_shift;
    logic [BW-1:0]     acc_mac;
    logic              last;

    // Input validity is judged once, on the operand as latched, so the flag
    // reflects what the user supplied rather than any wrap in the datapath.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign digit_bad[gi] = (bcd_in[gi*4 +: 4] > 4'd9);
            assign dd_adj[gi*4 +: 4] = (dd_q[gi*4 +: 4] >= 4'd5) ? dd_q[gi*4 +: 4] + 4'd3
                                                                  : dd_q[gi*4 +: 4];
        end
    endgenerate

    assign bad_digit = |digit_bad;
    assign ovf       = (64'(bin_in) > MAX_BIN);
    assign dd_shift  = {dd_adj[DW-2:0], acc_q, 1'b0};
    assign acc_mac   = acc_q * BW'(10) + BW'(src_q[DW-1 -: 4]);
    assign last      = mode_q ? (cnt_q == LAST_D2) : (cnt_q == LAST_B2);

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        inval_d   = inval_q;
        cnt_d     = cnt_q;
        src_d     = src_q;
        acc_d     = acc_q;
        dd_d      = dd_q;
        bin_out_d = bin_out_q;
        bcd_out_d = bcd_out_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = RUN;
                    mode_d  = mode;
                    src_d   = bcd_in;
                    acc_d   = mode ? bin_in : '0;
                    dd_d    = '0;
                    cnt_d   = '0;
                    inval_d = mode ? ovf : bad_digit;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (mode_q) begin
                    {dd_d, acc_d} = dd_shift;
                end else begin
                    acc_d = acc_mac;
                    src_d = src_q << 4;
                end
                if (last) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    err_d   = inval_q;
                    if (mode_q)
                        bcd_out_d = inval_q ? '0 : dd_shift[DW+BW-1:BW];
                    else
                        bin_out_d = inval_q ? '0 : acc_mac;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mode_q    <= 1'b0;
            inval_q   <= 1'b0;
            cnt_q     <= '0;
            src_q     <= '0;
            acc_q     <= '0;
            dd_q      <= '0;
            bin_out_q <= '0;
            bcd_out_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            inval_q   <= inval_d;
            cnt_q     <= cnt_d;
            src_q     <= src_d;
            acc_q     <= acc_d;
            dd_q      <= dd_d;
            bin_out_q <= bin_out_d;
            bcd_out_q <= bcd_out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bin_out = bin_out_q;
    assign bcd_out = bcd_out_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_bcd_bin_codec.sv
// Directed bench for bcd_bin_codec (DIGITS=3, BW=10): latency, results, error flags,
// handshake corner cases and mid-conversion reset.
module tb_bcd_bin_codec;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [11:0] bcd_in = '0;
    logic [9:0]  bin_in = '0;
    logic [9:0]  bin_out;
    logic [11:0] bcd_out;
    logic        busy, done, err;

    int n_assert = 0;
    int n_fail   = 0;
    int nd;

    always #5 clk = ~clk;

    bcd_bin_codec #(.DIGITS(3), .BW(10), .CW(5)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .mode    (mode),
        .bcd_in  (bcd_in),
        .bin_in  (bin_in),
        .bin_out (bin_out),
        .bcd_out (bcd_out),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One conversion; optionally pokes a conflicting start one cycle into RUN.
    task automatic conv(input logic m, input logic [11:0] b, input logic [9:0] bi, input bit poke);
        int lat;
        int bcnt;
        int n;
        n = m ? 10 : 3;
        @(negedge clk);
        mode = m; bcd_in = b; bin_in = bi; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        bcnt = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            if (poke && lat == 1) begin
                start = 1'b1; mode = ~m; bcd_in = 12'h111; bin_in = 10'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(n));
        chk("busy_cycles", 32'(bcnt), 32'(n));
        chk("busy_at_done", 32'(busy), 32'd0);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_bin_out", 32'(bin_out), 32'd0);
        chk("rst_bcd_out", 32'(bcd_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;

        conv(1'b0, 12'h227, 10'd0, 1'b0);
        chk("b2b_227", 32'(bin_out), 32'd227);
        chk("b2b_227_err", 32'(err), 32'd0);

        conv(1'b1, 12'h000, 10'd227, 1'b0);
        chk("d2b_227", 32'(bcd_out), 32'h227);
        chk("d2b_227_keep_bin", 32'(bin_out), 32'd227);
        conv(1'b1, 12'h000, 10'd0, 1'b0);
        chk("d2b_0", 32'(bcd_out), 32'h000);
        chk("d2b_0_err", 32'(err), 32'd0);

        conv(1'b0, 12'h999, 10'd0, 1'b0);
        chk("b2b_999", 32'(bin_out), 32'd999);
        conv(1'b1, 12'h000, 10'd999, 1'b0);
        chk("d2b_999", 32'(bcd_out), 32'h999);
        chk("d2b_999_err", 32'(err), 32'd0);
        conv(1'b1, 12'h000, 10'd1000, 1'b0);
        chk("d2b_1000", 32'(bcd_out), 32'h000);
        chk("d2b_1000_err", 32'(err), 32'd1);
        conv(1'b1, 12'h000, 10'd1023, 1'b0);
        chk("d2b_1023", 32'(bcd_out), 32'h000);
        chk("d2b_1023_err", 32'(err), 32'd1);
        chk("d2b_1023_keep_bin", 32'(bin_out), 32'd999);

        conv(1'b0, 12'h2A7, 10'd0, 1'b0);
        chk("b2b_2A7", 32'(bin_out), 32'd0);
        chk("b2b_2A7_err", 32'(err), 32'd1);
        conv(1'b0, 12'h009, 10'd0, 1'b0);
        chk("b2b_009", 32'(bin_out), 32'd9);
        chk("b2b_009_err", 32'(err), 32'd0);

        conv(1'b0, 12'h345, 10'd0, 1'b1);
        chk("poke_b2b_345", 32'(bin_out), 32'd345);
        conv(1'b1, 12'h000, 10'd618, 1'b1);
        chk("poke_d2b_618", 32'(bcd_out), 32'h618);

        // start held high across DONE: second conversion starts straight away
        @(negedge clk);
        mode = 1'b0; bcd_in = 12'h123; start = 1'b1;
        nd = 0;
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            if (done) nd++;
            if (i == 0) bcd_in = 12'h777;
            if (i == 3) begin
                chk("hold_first_done", 32'(done), 32'd1);
                chk("hold_first_val", 32'(bin_out), 32'd123);
                bcd_in = 12'h456;
            end
            if (i == 4) begin
                chk("hold_restart_busy", 32'(busy), 32'd1);
                start = 1'b0;
            end
            if (i == 7) begin
                chk("hold_second_done", 32'(done), 32'd1);
                chk("hold_second_val", 32'(bin_out), 32'd456);
            end
        end
        chk("hold_done_count", 32'(nd), 32'd2);

        conv(1'b1, 12'h000, 10'd500, 1'b0);
        chk("d2b_500", 32'(bcd_out), 32'h500);

        // reset in the middle of a binary->BCD run
        @(negedge clk);
        mode = 1'b1; bin_in = 10'd227; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_bin_out", 32'(bin_out), 32'd0);
        chk("abort_bcd_out", 32'(bcd_out), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("abort_no_done", 32'(nd), 32'd0);

        conv(1'b1, 12'h000, 10'd1, 1'b0);
        chk("post_d2b_1", 32'(bcd_out), 32'h001);
        conv(1'b0, 12'h050, 10'd0, 1'b0);
        chk("post_b2b_50", 32'(bin_out), 32'd50);
        chk("post_keep_bcd", 32'(bcd_out), 32'h001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_bin_codec.md
Name: bcd_bin_codec

Overview:
Parametrised, multi-cycle bidirectional converter between packed BCD and unsigned binary, generalising the team's fixed 3-digit BCD-to-binary converter. A start pulse selects the conversion direction. A busy/done handshake brackets each conversion, and invalid or overflowing input is flagged on an error output. It sits between keypad/display BCD logic and binary datapath arithmetic.

Parameters:
DIGITS, 3, number of BCD digits (1..8)
BW, 10, binary width; must satisfy 2^BW >= 10^DIGITS (3 digits -> 10)
CW, 5, step-counter width; must satisfy 2^CW > max(DIGITS, BW)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  start request, sampled on rising clk edge
mode  in  1  0 = BCD->binary, 1 = binary->BCD; sampled with start
bcd_in  in  4*DIGITS  packed BCD operand, MS digit in top nibble
bin_in  in  BW  binary operand
bin_out  out  BW  binary result (mode 0)
bcd_out  out  4*DIGITS  BCD result (mode 1)
busy  out  1  conversion in progress
done  out  1  one-cycle pulse; results valid
err  out  1  invalid input or overflow on the last conversion

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE; bin_out=0, bcd_out=0, busy=0, done=0, err=0; all internal registers cleared. Reset mid-conversion aborts it. No done is produced for the aborted operation.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge k: latch mode, bcd_in and bin_in; clear accumulator and step counter; busy<=1; go to RUN.
- RUN: one algorithm step per edge. Step count N = DIGITS (mode 0) or BW (mode 1).
- Completion: at edge k+N, write results, set done<=1 and busy<=0, go to DONE. Results appear N edges after start is sampled.
- DONE: lasts one cycle; done<=0 at the next edge.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back operation).
  - Otherwise go to IDLE.
- start while busy=1: ignored. Operands must not be re-latched.
- Outputs hold their last values until the next completion or reset. Only the result port of the active mode is updated; the other port keeps its previous value.
- Mode 0, BCD->binary:
  - Digits are consumed MS digit first.
  - Each step: acc <= acc*10 + digit. acc is BW bits wide; no truncation occurs because of the BW constraint.
  - If any digit > 9: err=1 and bin_out=0 at completion. Still runs N steps.
- Mode 1, binary->BCD (double dabble):
  - Each step: every BCD nibble >= 5 gets +3, then shift the {bcd, bin} register left by one bit.
  - If bin_in > 10^DIGITS - 1: err=1 and bcd_out=0 at completion. Still runs N steps. Overflow is detected from the latched operand, not from wrap-around.
- err is updated at every completion; cleared only on completion of a valid conversion or on reset.
- All arithmetic is unsigned. No combinational path from inputs to outputs.

Test Plan:
1. Reset, then mode=0, bcd_in=12'h227, 1-cycle start -> busy for 3 cycles; done pulses 3 edges after start; bin_out=10'd227 (0x0E3); err=0.
2. mode=1, bin_in=10'd227 -> done 10 edges after start; bcd_out=12'h227. Also bin_in=0 -> bcd_out=12'h000, err=0.
3. Range edges:
   - mode 0, bcd_in=12'h999 -> bin_out=999.
   - mode 1, bin_in=999 -> bcd_out=12'h999.
   - mode 1, bin_in=1000 and bin_in=1023 -> err=1, bcd_out=0.
4. mode=0, bcd_in=12'h2A7 -> err=1, bin_out=0. Then bcd_in=12'h009 -> bin_out=9, err cleared.
5. Handshake:
   - start pulsed again while busy -> ignored; result reflects the first operand.
   - start held high through DONE -> second conversion begins immediately; exactly one done per conversion.
6. rst_n low mid-RUN (mode 1, cycle 5) -> all outputs 0 immediately; no done pulse. After release, a fresh conversion completes correctly.
